// File: rtl/soc_system_pio_master.sv
// Avalon-MM initiator: one bus transaction and one response per fabric command.
// Define PIO_MASTER_VERIFY_EN to follow every write with a masked read-back compare.
module soc_system_pio_master #(
  parameter int                ADDR_W      = 2,
  parameter int                DATA_W      = 32,
  parameter int                TIMEOUT     = 255,
  parameter logic [DATA_W-1:0] VERIFY_MASK = DATA_W'(32'h0000FFFF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_writedata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_readdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic              avm_read,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

`ifdef PIO_MASTER_VERIFY_EN
  typedef enum logic [2:0] {IDLE, WR, RD, VFY, RESP} state_t;
`else
  typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;
`endif

  state_t            state, next_state;
  logic [CNT_W-1:0]  stall_cnt;
  logic              in_bus, timed_out;
  logic              cs_d, write_n_d, read_d;
  logic              rsp_load, rsp_err_d;
  logic [DATA_W-1:0] rsp_data_d;

`ifdef PIO_MASTER_VERIFY_EN
  assign in_bus = (state == WR) || (state == RD) || (state == VFY);
`else
  assign in_bus = (state == WR) || (state == RD);
`endif

  assign timed_out = (TIMEOUT != 0) && in_bus && avm_waitrequest &&
                     (stall_cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (cmd_valid) next_state = cmd_write ? WR : RD;
      WR: begin
        if (!avm_waitrequest)
`ifdef PIO_MASTER_VERIFY_EN
          next_state = VFY;
`else
          next_state = RESP;
`endif
        else if (timed_out)
          next_state = RESP;
      end
      RD:   if (!avm_waitrequest || timed_out) next_state = RESP;
`ifdef PIO_MASTER_VERIFY_EN
      VFY:  if (!avm_waitrequest || timed_out) next_state = RESP;
`endif
      RESP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // Strobes are decoded from next_state and registered, so they change only on
  // clock edges (or asynchronously on reset).
  always_comb begin
    cs_d      = 1'b0;
    write_n_d = 1'b1;
    read_d    = 1'b0;
    case (next_state)
      WR: begin cs_d = 1'b1; write_n_d = 1'b0; end
      RD: begin cs_d = 1'b1; read_d    = 1'b1; end
`ifdef PIO_MASTER_VERIFY_EN
      VFY: begin cs_d = 1'b1; read_d   = 1'b1; end
`endif
      default: ;
    endcase
  end

  // A timeout or a plain write completion responds with zero data.
  always_comb begin
    rsp_load   = in_bus && (next_state == RESP);
    rsp_data_d = '0;
    rsp_err_d  = 1'b0;
    if (timed_out) begin
      rsp_err_d = 1'b1;
    end else if (state == RD) begin
      rsp_data_d = avm_readdata;
    end
`ifdef PIO_MASTER_VERIFY_EN
    else if (state == VFY) begin
      rsp_data_d = avm_readdata;
      rsp_err_d  = |((avm_readdata ^ avm_writedata) & VERIFY_MASK);
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avm_address    <= '0;
      avm_writedata  <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_read       <= 1'b0;
      rsp_readdata   <= '0;
      rsp_error      <= 1'b0;
      stall_cnt      <= '0;
    end else begin
      avm_chipselect <= cs_d;
      avm_write_n    <= write_n_d;
      avm_read       <= read_d;
      if (state == IDLE && cmd_valid) begin
        avm_address   <= cmd_address;
        avm_writedata <= cmd_writedata;
      end
      if (next_state != state)
        stall_cnt <= '0;
      else if (in_bus && avm_waitrequest && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (rsp_load) begin
        rsp_readdata <= rsp_data_d;
        rsp_error    <= rsp_err_d;
      end
    end
  end

endmodule

// File: tb/tb_soc_system_pio_master.sv
// Directed bench for soc_system_pio_master against a 16-bit PIO slave model with
// programmable wait states; expectations adapt to PIO_MASTER_VERIFY_EN.
module tb_soc_system_pio_master;

  localparam int ADDR_W  = 2;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;
`ifdef PIO_MASTER_VERIFY_EN
  localparam int VFY = 1;
`else
  localparam int VFY = 0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_address;
  logic [DATA_W-1:0] cmd_writedata;
  logic              rsp_valid, rsp_error;
  logic [DATA_W-1:0] rsp_readdata;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect, avm_write_n, avm_read, avm_waitrequest;
  logic [DATA_W-1:0] avm_writedata, avm_readdata;

  always #5 clk = ~clk;

  soc_system_pio_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .VERIFY_MASK(32'h0000FFFF)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
    .rsp_valid(rsp_valid), .rsp_readdata(rsp_readdata), .rsp_error(rsp_error),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_read(avm_read),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  // Slave model: stores only the low 16 bits; 'fault' forces stored bit 0 low.
  logic [DATA_W-1:0] mem [4];
  logic              stuck, fault;
  int                stall_req, stall_cnt;

  assign avm_waitrequest = avm_chipselect && (stuck || (stall_cnt < stall_req));
  assign avm_readdata    = mem[avm_address];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (!avm_chipselect)     stall_cnt <= 0;
      else if (avm_waitrequest) stall_cnt <= stall_cnt + 1;
      if (avm_chipselect && !avm_write_n && !avm_waitrequest)
        mem[avm_address] <= {16'h0, avm_writedata[15:1], avm_writedata[0] & ~fault};
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    int          stalls;
    logic        stuck;
    logic        fault;
    int          exp_wr;     // cycles with chipselect && !write_n
    int          exp_rd;     // cycles with chipselect && read
    int          exp_lat;    // cycles from acceptance to rsp_valid
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  // Called at a negedge with the DUT idle; returns at the negedge after RESP.
  task automatic apply_vec(input int idx, input vec_t c);
    int          nwr, nrd, lat, nbad;
    logic        got;
    logic [31:0] rdata;
    logic        rerr;
    nwr = 0; nrd = 0; lat = 0; nbad = 0; got = 1'b0; rdata = '0; rerr = 1'b0;
    stall_req     = c.stalls;
    stuck         = c.stuck;
    fault         = c.fault;
    cmd_valid     = 1'b1;
    cmd_write     = c.wr;
    cmd_address   = c.addr;
    cmd_writedata = c.wdata;
    check($sformatf("v%0d_cmd_ready", idx), cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 1; i <= 20 && !got; i++) begin
      if (avm_chipselect && !avm_write_n) nwr++;
      if (avm_chipselect && avm_read)     nrd++;
      if (avm_chipselect && (avm_address != c.addr ||
          (!avm_write_n && avm_writedata != c.wdata))) nbad++;
      if (rsp_valid) begin
        got = 1'b1; lat = i; rdata = rsp_readdata; rerr = rsp_error;
      end
      @(negedge clk);
    end
    check($sformatf("v%0d_rsp_seen", idx), got, 1);
    check($sformatf("v%0d_wr_cycles", idx), nwr, c.exp_wr);
    check($sformatf("v%0d_rd_cycles", idx), nrd, c.exp_rd);
    check($sformatf("v%0d_bus_fields", idx), nbad, 0);
    check($sformatf("v%0d_latency", idx), lat, c.exp_lat);
    check($sformatf("v%0d_rsp_data", idx), rdata, c.exp_data);
    check($sformatf("v%0d_rsp_error", idx), rerr, c.exp_err);
    check($sformatf("v%0d_idle_after", idx), {cmd_ready, rsp_valid, avm_chipselect}, 3'b100);
    check($sformatf("v%0d_data_hold", idx), rsp_readdata, c.exp_data);
    stuck = 1'b0; stall_req = 0; fault = 1'b0;
  endtask

  int          acc_t [4];
  int          rsp_t [4];
  logic [31:0] rsp_d [4];
  int          n_acc, n_rsp;
  logic        acc_now;

  initial begin
    //           wr    addr   wdata          st stk    flt    wr rd   lat    data                         err
    vecs[0]  = '{1'b1, 2'd0, 32'h0000BEEF, 0, 1'b0, 1'b0, 1, VFY, 2+VFY, VFY ? 32'h0000BEEF : 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 2'd0, 32'h0,        0, 1'b0, 1'b0, 0, 1,   2,     32'h0000BEEF,                1'b0};
    vecs[2]  = '{1'b1, 2'd1, 32'h00001234, 0, 1'b0, 1'b0, 1, VFY, 2+VFY, VFY ? 32'h00001234 : 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 2'd1, 32'h0,        3, 1'b0, 1'b0, 0, 4,   5,     32'h00001234,                1'b0};
    vecs[4]  = '{1'b1, 2'd2, 32'h0001ABCD, 2, 1'b0, 1'b0, 3, VFY, 4+VFY, VFY ? 32'h0000ABCD : 32'h0, 1'b0};
    vecs[5]  = '{1'b0, 2'd2, 32'h0,        4, 1'b0, 1'b0, 0, 5,   6,     32'h0000ABCD,                1'b0};
    vecs[6]  = '{1'b1, 2'd3, 32'hFFFF5A5A, 0, 1'b1, 1'b0, 5, 0,   6,     32'h0,                       1'b1};
    vecs[7]  = '{1'b0, 2'd3, 32'h0,        0, 1'b0, 1'b0, 0, 1,   2,     32'h0,                       1'b0};
    vecs[8]  = '{1'b0, 2'd2, 32'h0,        0, 1'b0, 1'b0, 0, 1,   2,     32'h0000ABCD,                1'b0};
    vecs[9]  = '{1'b0, 2'd0, 32'h0,        5, 1'b0, 1'b0, 0, 5,   6,     32'h0,                       1'b1};
    vecs[10] = '{1'b1, 2'd2, 32'h0001ABCD, 0, 1'b0, 1'b1, 1, VFY, 2+VFY, VFY ? 32'h0000ABCC : 32'h0, (VFY != 0)};
    vecs[11] = '{1'b0, 2'd2, 32'h0,        0, 1'b0, 1'b0, 0, 1,   2,     32'h0000ABCC,                1'b0};
    vecs[12] = '{1'b1, 2'd1, 32'h12340000, 0, 1'b0, 1'b0, 1, VFY, 2+VFY, 32'h0,                       1'b0};
    vecs[13] = '{1'b0, 2'd1, 32'h0,        0, 1'b0, 1'b0, 0, 1,   2,     32'h0,                       1'b0};

    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_writedata = '0;
    stuck = 1'b0; fault = 1'b0; stall_req = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_rsp", {rsp_valid, rsp_error}, 2'b00);
    check("reset_rsp_data", rsp_readdata, 0);
    check("reset_strobes", {avm_chipselect, avm_write_n, avm_read}, 3'b010);
    check("reset_bus_fields", {30'h0, avm_address} | avm_writedata, 0);

    for (int v = 0; v < NV; v++) apply_vec(v, vecs[v]);

    // Back-to-back: cmd_valid held across a write then a read of the same word.
    n_acc = 0; n_rsp = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 2'd1; cmd_writedata = 32'h00002222;
    for (int t = 0; t < 12; t++) begin
      if (rsp_valid && n_rsp < 4) begin
        rsp_t[n_rsp] = t; rsp_d[n_rsp] = rsp_readdata; n_rsp++;
      end
      acc_now = cmd_valid && cmd_ready;
      if (acc_now && n_acc < 4) begin acc_t[n_acc] = t; n_acc++; end
      @(negedge clk);
      if (acc_now) begin
        if (n_acc == 1) begin cmd_write = 1'b0; cmd_writedata = '0; end
        else cmd_valid = 1'b0;
      end
    end
    check("b2b_accepts", n_acc, 2);
    check("b2b_responses", n_rsp, 2);
    if (n_acc == 2 && n_rsp == 2) begin
      check("b2b_second_accept", acc_t[1], rsp_t[0] + 1);
      check("b2b_read_latency", rsp_t[1] - acc_t[1], 2);
      check("b2b_read_data", rsp_d[1], 32'h00002222);
    end

    // Reset during a stalled write.
    stuck = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 2'd0; cmd_writedata = 32'h0000CAFE;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("midrst_strobe_before", {avm_chipselect, avm_write_n}, 2'b10);
    reset = 1'b1;
    #1;
    check("midrst_strobe_async", {avm_chipselect, avm_write_n}, 2'b01);
    @(negedge clk);
    reset = 1'b0; stuck = 1'b0;
    n_rsp = 0;
    for (int t = 0; t < 8; t++) begin
      if (rsp_valid) n_rsp++;
      @(negedge clk);
    end
    check("midrst_no_rsp", n_rsp, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_rsp_data", rsp_readdata, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
